// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access.
// Each transaction is granted in IDLE, then runs command, fixed wait states and a one-cycle response.
module unified_mem_arbiter #(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int MEM_LATENCY  = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   output logic                  if_ready,
   output logic [DATA_WIDTH-1:0] if_rdata,
   input  logic                  dm_req,
   input  logic                  dm_we,
   input  logic [ADDR_WIDTH-1:0] dm_addr,
   input  logic [DATA_WIDTH-1:0] dm_wdata,
   input  logic [1:0]            dm_wtype,
   output logic                  dm_ready,
   output logic [DATA_WIDTH-1:0] dm_rdata,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [1:0]            mem_wtype,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  busy
);

   typedef enum logic [1:0] {IDLE, CMD, WAIT, RESP} state_t;

   localparam logic [3:0] WAIT_INIT  = 4'(MEM_LATENCY - 1);
   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

   state_t                  state;
   state_t                  state_next;
   logic                    owner_dm;
   logic [3:0]              wait_cnt;
   logic [3:0]              starve_cnt;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic                    we_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [1:0]              wtype_q;
   logic [DATA_WIDTH-1:0]   if_rdata_q;
   logic [DATA_WIDTH-1:0]   dm_rdata_q;
   logic                    any_req;
   logic                    grant_dm;

   // Data port wins unless fetch has already been passed over STARVE_LIMIT times in a row.
   assign any_req  = if_req | dm_req;
   assign grant_dm = dm_req & ~(if_req & (starve_cnt == STARVE_MAX));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      mem_en     = 1'b0;
      if_ready   = 1'b0;
      dm_ready   = 1'b0;
      busy       = 1'b1;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (any_req) begin
               state_next = CMD;
            end
         end
         CMD: begin
            mem_en     = 1'b1;
            state_next = we_q ? RESP : WAIT;
         end
         WAIT: begin
            if (wait_cnt == 4'd0) begin
               state_next = RESP;
            end
         end
         RESP: begin
            if_ready   = ~owner_dm;
            dm_ready   = owner_dm;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner_dm   <= 1'b0;
         wait_cnt   <= 4'd0;
         starve_cnt <= 4'd0;
         addr_q     <= '0;
         we_q       <= 1'b0;
         wdata_q    <= '0;
         wtype_q    <= 2'b00;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
      end else begin
         if (state == IDLE) begin
            if (!if_req || !grant_dm) begin
               starve_cnt <= 4'd0;
            end else if (starve_cnt != STARVE_MAX) begin
               starve_cnt <= starve_cnt + 4'd1;
            end
            if (any_req) begin
               owner_dm <= grant_dm;
               addr_q   <= grant_dm ? dm_addr : if_addr;
               we_q     <= grant_dm & dm_we;
               if (grant_dm) begin
                  wdata_q <= dm_wdata;
                  wtype_q <= dm_wtype;
               end
            end
         end
         // Read data is captured on the edge that ends the last wait cycle.
         if (state == CMD) begin
            wait_cnt <= WAIT_INIT;
         end else if (state == WAIT) begin
            if (wait_cnt != 4'd0) begin
               wait_cnt <= wait_cnt - 4'd1;
            end else if (owner_dm) begin
               dm_rdata_q <= mem_rdata;
            end else begin
               if_rdata_q <= mem_rdata;
            end
         end
      end
   end

   assign mem_addr  = addr_q;
   assign mem_we    = we_q & mem_en;
   assign mem_wdata = wdata_q;
   assign mem_wtype = wtype_q;
   assign if_rdata  = if_rdata_q;
   assign dm_rdata  = dm_rdata_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: a transaction-level reference model predicts grant order, ready timing
// and read data for random and directed traffic; two extra instances cover other memory latencies.
module tb_unified_mem_arbiter;

   localparam int NDUT   = 3;
   localparam int LAT0   = 2;
   localparam int STARVE = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        memInit;

   logic        if_req    [NDUT];
   logic [31:0] if_addr   [NDUT];
   logic        if_ready  [NDUT];
   logic [31:0] if_rdata  [NDUT];
   logic        dm_req    [NDUT];
   logic        dm_we     [NDUT];
   logic [31:0] dm_addr   [NDUT];
   logic [31:0] dm_wdata  [NDUT];
   logic [1:0]  dm_wtype  [NDUT];
   logic        dm_ready  [NDUT];
   logic [31:0] dm_rdata  [NDUT];
   logic        mem_en    [NDUT];
   logic        mem_we    [NDUT];
   logic [31:0] mem_addr  [NDUT];
   logic [31:0] mem_wdata [NDUT];
   logic [1:0]  mem_wtype [NDUT];
   logic [31:0] mem_rdata [NDUT];
   logic        busy      [NDUT];

   logic [31:0] devMem   [64];
   logic        devValid [64];

   int vecCount = 0;
   int errCount = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] defaultWord(logic [31:0] a);
      if (a == 32'h10) return 32'h00500093;
      return {a[7:0], 8'h5A, ~a[7:0], a[7:0] ^ 8'h3C};
   endfunction

   function automatic logic [31:0] readDev(logic [31:0] a);
      return devValid[a[7:2]] ? devMem[a[7:2]] : defaultWord(a);
   endfunction

   // Shared backing store; only instance 0 ever issues writes.
   always @(posedge clk) begin
      if (memInit) begin
         for (int i = 0; i < 64; i++) devValid[i] <= 1'b0;
      end else if (mem_en[0] && mem_we[0]) begin
         devMem[mem_addr[0][7:2]]   <= mem_wdata[0];
         devValid[mem_addr[0][7:2]] <= 1'b1;
      end
   end

   for (genvar g = 0; g < NDUT; g++) begin : gen_dut
      localparam int L = (g == 0) ? LAT0 : ((g == 1) ? 1 : 7);
      int          cnt = 0;
      logic [31:0] data;
      logic [31:0] junk;

      unified_mem_arbiter #(
         .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(L), .STARVE_LIMIT(STARVE)
      ) dut (
         .clk(clk), .rst_n(rst_n),
         .if_req(if_req[g]), .if_addr(if_addr[g]), .if_ready(if_ready[g]), .if_rdata(if_rdata[g]),
         .dm_req(dm_req[g]), .dm_we(dm_we[g]), .dm_addr(dm_addr[g]), .dm_wdata(dm_wdata[g]),
         .dm_wtype(dm_wtype[g]), .dm_ready(dm_ready[g]), .dm_rdata(dm_rdata[g]),
         .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]),
         .mem_wtype(mem_wtype[g]), .mem_rdata(mem_rdata[g]), .busy(busy[g])
      );

      // Memory returns valid data only during the cycle L cycles after the command; garbage otherwise.
      always @(posedge clk) begin
         junk <= $urandom;
         if (mem_en[g] && !mem_we[g]) begin
            cnt  <= L;
            data <= readDev(mem_addr[g]);
         end else if (cnt > 0) begin
            cnt <= cnt - 1;
         end
      end
      assign mem_rdata[g] = (cnt == 1) ? data : junk;
   end

   // Reference model state for instance 0
   int          cyc = 0;
   bit          mActive = 0;
   bit          mOwnerDm;
   bit          mWe;
   int          mGrantCyc;
   int          mDoneCyc;
   logic [31:0] mAddr;
   logic [31:0] mWdata;
   logic [1:0]  mWtype;
   logic [31:0] mExpData;
   int          mStarve = 0;
   logic [31:0] mIfRdata = '0;
   logic [31:0] mDmRdata = '0;
   logic [31:0] modelMem   [64];
   bit          modelValid [64];
   bit          grantLog [$];

   // Requester behaviour for instance 0
   bit ifWant = 0, ifGranted = 0, dmWant = 0, dmGranted = 0;
   int ifRate = 0, dmRate = 0;
   bit garbleEn = 0, dmWeForce = 0;
   int lastIfReady = -1, lastDmReady = -1, lastMemEn = -1;

   function automatic logic [31:0] modelRead(logic [31:0] a);
      return modelValid[a[7:2]] ? modelMem[a[7:2]] : defaultWord(a);
   endfunction

   function automatic logic [31:0] randAddr();
      logic [31:0] a;
      a = {24'h0, 6'($urandom), 2'b00};
      return a;
   endfunction

   task automatic checkOutput(string tag, logic [63:0] obs, logic [63:0] exp);
      vecCount++;
      if (obs !== exp) begin
         errCount++;
         $display("[TB] FAIL %s @cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic applyStimulus();
      if (ifGranted && garbleEn) begin
         if_req[0]  = ($urandom_range(0, 2) != 0);
         if_addr[0] = $urandom;
      end else begin
         if (!ifWant && $urandom_range(0, 99) < ifRate) begin
            ifWant     = 1;
            if_addr[0] = randAddr();
         end
         if_req[0] = ifWant;
      end
      if (dmGranted && garbleEn) begin
         dm_req[0]   = ($urandom_range(0, 2) != 0);
         dm_we[0]    = 1'($urandom);
         dm_addr[0]  = $urandom;
         dm_wdata[0] = $urandom;
         dm_wtype[0] = 2'($urandom);
      end else begin
         if (!dmWant && $urandom_range(0, 99) < dmRate) begin
            dmWant      = 1;
            dm_we[0]    = dmWeForce ? 1'b1 : 1'($urandom);
            dm_addr[0]  = randAddr();
            dm_wdata[0] = $urandom;
            dm_wtype[0] = 2'($urandom);
         end
         dm_req[0] = dmWant;
      end
   endtask

   task automatic runCycle();
      bit dmWins, isDone, expMemEn;
      @(posedge clk);
      #1;
      cyc++;
      applyStimulus();
      if (!mActive) begin
         if (if_req[0] || dm_req[0]) begin
            dmWins  = dm_req[0] && !(if_req[0] && mStarve == STARVE);
            mStarve = (dmWins && if_req[0]) ? ((mStarve + 1 > STARVE) ? STARVE : mStarve + 1) : 0;
            mOwnerDm  = dmWins;
            mWe       = dmWins ? dm_we[0] : 1'b0;
            mAddr     = dmWins ? dm_addr[0] : if_addr[0];
            mWdata    = dm_wdata[0];
            mWtype    = dm_wtype[0];
            mGrantCyc = cyc;
            mDoneCyc  = cyc + (mWe ? 2 : LAT0 + 2);
            mActive   = 1;
            grantLog.push_back(dmWins);
            if (dmWins) dmGranted = 1; else ifGranted = 1;
            if (mWe) begin
               modelMem[mAddr[7:2]]   = mWdata;
               modelValid[mAddr[7:2]] = 1;
            end else begin
               mExpData = modelRead(mAddr);
            end
         end else begin
            mStarve = 0;
         end
      end
      expMemEn = mActive && (cyc == mGrantCyc + 1);
      isDone   = mActive && (cyc == mDoneCyc);
      if (isDone && !mWe) begin
         if (mOwnerDm) mDmRdata = mExpData; else mIfRdata = mExpData;
      end
      @(negedge clk);
      checkOutput("if_ready", if_ready[0], isDone && !mOwnerDm);
      checkOutput("dm_ready", dm_ready[0], isDone && mOwnerDm);
      checkOutput("busy", busy[0], mActive && cyc != mGrantCyc);
      checkOutput("mem_en", mem_en[0], expMemEn);
      checkOutput("mem_we", mem_we[0], expMemEn && mWe);
      if (expMemEn) begin
         checkOutput("mem_addr", mem_addr[0], mAddr);
         if (mWe) begin
            checkOutput("mem_wdata", mem_wdata[0], mWdata);
            checkOutput("mem_wtype", mem_wtype[0], mWtype);
         end
      end
      checkOutput("if_rdata", if_rdata[0], mIfRdata);
      checkOutput("dm_rdata", dm_rdata[0], mDmRdata);
      if (if_ready[0]) lastIfReady = cyc;
      if (dm_ready[0]) lastDmReady = cyc;
      if (mem_en[0])   lastMemEn   = cyc;
      if (isDone) begin
         mActive = 0;
         if (mOwnerDm) begin dmWant = 0; dmGranted = 0; end
         else          begin ifWant = 0; ifGranted = 0; end
      end
   endtask

   task automatic runUntilIdle(int maxCycles);
      int n = 0;
      while ((mActive || ifWant || dmWant) && n < maxCycles) begin
         runCycle();
         n++;
      end
      checkOutput("drain timeout", n >= maxCycles, 0);
   endtask

   task automatic checkAllZero(string tag);
      checkOutput({tag, " if_ready"}, if_ready[0], 0);
      checkOutput({tag, " dm_ready"}, dm_ready[0], 0);
      checkOutput({tag, " mem_en"}, mem_en[0], 0);
      checkOutput({tag, " mem_we"}, mem_we[0], 0);
      checkOutput({tag, " mem_addr"}, mem_addr[0], 0);
      checkOutput({tag, " mem_wdata"}, mem_wdata[0], 0);
      checkOutput({tag, " mem_wtype"}, mem_wtype[0], 0);
      checkOutput({tag, " busy"}, busy[0], 0);
      checkOutput({tag, " if_rdata"}, if_rdata[0], 0);
      checkOutput({tag, " dm_rdata"}, dm_rdata[0], 0);
   endtask

   task automatic sweepRead(int g, int lat, bit useDm, logic [31:0] addr);
      int n = 0;
      @(posedge clk);
      #1;
      if (useDm) begin
         dm_req[g] = 1; dm_we[g] = 0; dm_addr[g] = addr;
      end else begin
         if_req[g] = 1; if_addr[g] = addr;
      end
      while (n < 40) begin
         @(negedge clk);
         if (useDm ? dm_ready[g] : if_ready[g]) break;
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput("sweep latency", n, lat + 2);
      checkOutput("sweep other ready", useDm ? if_ready[g] : dm_ready[g], 0);
      checkOutput("sweep rdata", useDm ? dm_rdata[g] : if_rdata[g], modelRead(addr));
      @(posedge clk);
      #1;
      if_req[g] = 0;
      dm_req[g] = 0;
   endtask

   initial begin
      int start, n;
      rst_n   = 0;
      memInit = 1;
      for (int g = 0; g < NDUT; g++) begin
         if_req[g] = 0; if_addr[g] = '0; dm_req[g] = 0; dm_we[g] = 0;
         dm_addr[g] = '0; dm_wdata[g] = '0; dm_wtype[g] = '0;
      end
      for (int i = 0; i < 64; i++) modelValid[i] = 0;
      #1;
      checkAllZero("reset");
      repeat (3) @(posedge clk);
      #2;
      memInit = 0;
      rst_n   = 1;

      // Latency sweep on the MEM_LATENCY = 1 and 7 instances
      sweepRead(1, 1, 0, 32'h10);
      sweepRead(1, 1, 1, 32'h30);
      sweepRead(2, 7, 0, 32'h10);
      sweepRead(2, 7, 1, 32'h30);

      // Single fetch
      ifWant = 1; if_addr[0] = 32'h10; start = cyc + 1;
      runUntilIdle(20);
      checkOutput("fetch mem_en cycle", lastMemEn - start, 1);
      checkOutput("fetch ready cycle", lastIfReady - start, 4);
      checkOutput("fetch rdata", if_rdata[0], 32'h00500093);
      checkOutput("fetch no dm_ready", lastDmReady, -1);

      // Data store then read-back
      dmWant = 1; dm_we[0] = 1; dm_addr[0] = 32'h8; dm_wdata[0] = 32'hDEADBEEF; dm_wtype[0] = 2'b01;
      start = cyc + 1;
      runUntilIdle(20);
      checkOutput("store mem_en cycle", lastMemEn - start, 1);
      checkOutput("store ready cycle", lastDmReady - start, 2);
      dmWant = 1; dm_we[0] = 0; dm_addr[0] = 32'h8;
      runUntilIdle(20);
      checkOutput("store readback", dm_rdata[0], 32'hDEADBEEF);

      // Contention: data read wins, fetch follows at the next IDLE
      dmWant = 1; dm_we[0] = 0; dm_addr[0] = 32'h4;
      ifWant = 1; if_addr[0] = 32'h20;
      start = cyc + 1;
      runUntilIdle(40);
      checkOutput("contention dm ready", lastDmReady - start, 4);
      checkOutput("contention if ready", lastIfReady - start, 9);
      checkOutput("contention dm rdata", dm_rdata[0], defaultWord(32'h4));
      checkOutput("contention if rdata", if_rdata[0], defaultWord(32'h20));

      // Starvation: continuous data writes against a persistent fetch
      grantLog.delete();
      ifRate = 100; dmRate = 100; dmWeForce = 1;
      n = 0;
      while (grantLog.size() < 10 && n < 300) begin
         runCycle();
         n++;
      end
      ifRate = 0; dmRate = 0; dmWeForce = 0;
      runUntilIdle(100);
      checkOutput("starve grant count", grantLog.size() >= 10, 1);
      for (int i = 0; i < 10 && i < grantLog.size(); i++) begin
         checkOutput("starve grant order", grantLog[i], (i % 5 == 4) ? 0 : 1);
      end

      // Random traffic with inputs scrambled after grant
      ifRate = 40; dmRate = 40; garbleEn = 1;
      repeat (800) runCycle();
      ifRate = 0; dmRate = 0;
      runUntilIdle(100);
      garbleEn = 0;

      // Reset in the middle of a read
      dmWant = 1; dm_we[0] = 0; dm_addr[0] = randAddr();
      n = 0;
      runCycle();
      while (!(mActive && cyc == mGrantCyc + 2) && n < 10) begin
         runCycle();
         n++;
      end
      checkOutput("reach wait state", n < 10, 1);
      rst_n = 0;
      #1;
      checkAllZero("midreset");
      mActive = 0; mStarve = 0; mIfRdata = '0; mDmRdata = '0;
      ifWant = 0; ifGranted = 0; dmWant = 0; dmGranted = 0;
      if_req[0] = 0; dm_req[0] = 0;
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1;
      lastIfReady = -1; lastDmReady = -1;
      repeat (6) runCycle();
      checkOutput("no ready after reset", (lastIfReady != -1) || (lastDmReady != -1), 0);
      ifWant = 1; if_addr[0] = 32'h10; start = cyc + 1;
      runUntilIdle(20);
      checkOutput("post-reset fetch cycle", lastIfReady - start, 4);
      checkOutput("post-reset fetch rdata", if_rdata[0], 32'h00500093);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
      $finish;
   end

endmodule
